// File: rtl/bsg_tag_pkg.sv
// Shared types for the bsg_tag serial transmitter: FSM states, request record
// and small elaboration-time helpers.
package bsg_tag_pkg;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Request field widths for the default configuration (32 clients, 4-bit length)
  localparam int els_gp       = 32;
  localparam int lg_els_gp    = safe_clog2(els_gp);
  localparam int lg_width_gp  = 4;
  localparam int payload_w_gp = (1 << lg_width_gp) - 1;

  typedef enum logic [2:0] {
    IDLE,
    RST_SEQ,
    START,
    ID,
    DNR,
    LEN,
    PAYLOAD,
    GAP
  } bsg_tag_tx_state_e;

  typedef struct packed {
    logic                    master_reset;
    logic [lg_els_gp-1:0]    node_id;
    logic                    data_not_reset;
    logic [lg_width_gp-1:0]  len;
    logic [payload_w_gp-1:0] payload;
  } bsg_tag_tx_req_s;

endpackage

// File: rtl/bsg_tag_tx_serializer.sv
// Serializes tag requests into start/id/dnr/len/payload bit streams (LSB first),
// or a run of ones for a master reset, each followed by an idle gap.
module bsg_tag_tx_serializer
  import bsg_tag_pkg::*;
#(
  parameter int els_p        = 32,
  parameter int lg_width_p   = 4,
  parameter int reset_ones_p = 64,
  parameter int gap_p        = 4,
  localparam int lg_els_lp    = safe_clog2(els_p),
  localparam int payload_w_lp = (1 << lg_width_p) - 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic                    master_reset_i,
  input  logic [lg_els_lp-1:0]    node_id_i,
  input  logic                    data_not_reset_i,
  input  logic [lg_width_p-1:0]   len_i,
  input  logic [payload_w_lp-1:0] payload_i,
  output logic                    tag_data_o,
  output logic                    tag_en_o
);

  localparam int cnt_max_lp = max2(max2(reset_ones_p, gap_p), max2(lg_els_lp, 1 << lg_width_p));
  localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);
  localparam int sh_w_lp    = max2(lg_els_lp, payload_w_lp);

  bsg_tag_tx_state_e state_r, state_n;
  logic [cnt_w_lp-1:0]     cnt_r, cnt_n;
  logic [sh_w_lp-1:0]      sh_r, sh_n;
  logic                    data_n;
  logic                    capture;
  logic                    dnr_r;
  logic [lg_width_p-1:0]   len_r;
  logic [payload_w_lp-1:0] payload_r;

  assign ready_o = (state_r == IDLE);

  // data_n is the bit the wire carries during the state being entered
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    sh_n    = sh_r;
    data_n  = 1'b0;
    capture = 1'b0;
    case (state_r)
      IDLE: begin
        if (v_i) begin
          capture = 1'b1;
          data_n  = 1'b1;
          if (master_reset_i) begin
            state_n = RST_SEQ;
            cnt_n   = cnt_w_lp'(reset_ones_p - 1);
          end else begin
            state_n = START;
            cnt_n   = '0;
            sh_n    = sh_w_lp'(node_id_i);
          end
        end
      end
      RST_SEQ: begin
        if (cnt_r == '0) begin
          state_n = GAP;
          cnt_n   = cnt_w_lp'(gap_p - 1);
        end else begin
          cnt_n  = cnt_r - 1'b1;
          data_n = 1'b1;
        end
      end
      START: begin
        state_n = ID;
        cnt_n   = cnt_w_lp'(lg_els_lp - 1);
        data_n  = sh_r[0];
        sh_n    = sh_r >> 1;
      end
      ID: begin
        if (cnt_r == '0) begin
          state_n = DNR;
          data_n  = dnr_r;
        end else begin
          cnt_n  = cnt_r - 1'b1;
          data_n = sh_r[0];
          sh_n   = sh_r >> 1;
        end
      end
      DNR: begin
        state_n = LEN;
        cnt_n   = cnt_w_lp'(lg_width_p - 1);
        data_n  = len_r[0];
        sh_n    = sh_w_lp'(len_r) >> 1;
      end
      LEN: begin
        if (cnt_r != '0) begin
          cnt_n  = cnt_r - 1'b1;
          data_n = sh_r[0];
          sh_n   = sh_r >> 1;
        end else if (len_r == '0) begin
          state_n = GAP;
          cnt_n   = cnt_w_lp'(gap_p - 1);
        end else begin
          state_n = PAYLOAD;
          cnt_n   = cnt_w_lp'(len_r) - 1'b1;
          data_n  = payload_r[0];
          sh_n    = sh_w_lp'(payload_r) >> 1;
        end
      end
      PAYLOAD: begin
        if (cnt_r != '0) begin
          cnt_n  = cnt_r - 1'b1;
          data_n = sh_r[0];
          sh_n   = sh_r >> 1;
        end else begin
          state_n = GAP;
          cnt_n   = cnt_w_lp'(gap_p - 1);
        end
      end
      GAP: begin
        if (cnt_r == '0) state_n = IDLE;
        else             cnt_n   = cnt_r - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      sh_r       <= '0;
      tag_data_o <= 1'b0;
      tag_en_o   <= 1'b0;
      dnr_r      <= 1'b0;
      len_r      <= '0;
      payload_r  <= '0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      sh_r       <= sh_n;
      tag_data_o <= data_n;
      tag_en_o   <= (state_n != IDLE);
      if (capture) begin
        dnr_r     <= data_not_reset_i;
        len_r     <= len_i;
        payload_r <= payload_i;
      end
    end
  end

endmodule

// File: tb/tb_bsg_tag_tx_serializer.sv
// Directed and randomized bench for bsg_tag_tx_serializer with a wire-format
// model and a stream-decoding client model.
module tb_bsg_tag_tx_serializer;
  import bsg_tag_pkg::*;

  localparam int els_lp  = 32;
  localparam int lg_els  = 5;
  localparam int lg_w    = 4;
  localparam int ones_lp = 64;
  localparam int gap_lp  = 4;

  typedef bit bitq_t[$];

  logic        clk = 1'b0, rst_n = 1'b0, v = 1'b0, mr = 1'b0, dnr = 1'b0;
  logic [4:0]  nid = '0;
  logic [3:0]  len = '0;
  logic [14:0] pay = '0;
  logic        ready, tdata, ten;

  int checks = 0, failures = 0;
  bit dec_en = 1'b1;
  logic [14:0] client_data [els_lp] = '{default: '0};
  logic [14:0] exp_client  [els_lp] = '{default: '0};

  always #5 clk = ~clk;

  bsg_tag_tx_serializer #(.els_p(els_lp), .lg_width_p(lg_w), .reset_ones_p(ones_lp), .gap_p(gap_lp)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .ready_o(ready), .master_reset_i(mr),
    .node_id_i(nid), .data_not_reset_i(dnr), .len_i(len), .payload_i(pay),
    .tag_data_o(tdata), .tag_en_o(ten));

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected wire bits for one request, straight from the packet format
  function automatic bitq_t build(input bsg_tag_tx_req_s r);
    bitq_t q;
    if (r.master_reset) begin
      for (int i = 0; i < ones_lp; i++) q.push_back(1'b1);
    end else begin
      q.push_back(1'b1);
      for (int i = 0; i < lg_els; i++) q.push_back(r.node_id[i]);
      q.push_back(r.data_not_reset);
      for (int i = 0; i < lg_w; i++) q.push_back(r.len[i]);
      for (int i = 0; i < int'(r.len); i++) q.push_back(r.payload[i]);
    end
    return q;
  endfunction

  function automatic bsg_tag_tx_req_s mk(input bit m, input int id, input bit d, input int l, input int p);
    bsg_tag_tx_req_s r;
    r.master_reset = m; r.node_id = 5'(id); r.data_not_reset = d; r.len = 4'(l); r.payload = 15'(p);
    return r;
  endfunction

  function automatic bsg_tag_tx_req_s rand_req();
    return mk(1'b0, int'($urandom_range(els_lp - 1, 0)), 1'($urandom), int'($urandom_range(15, 0)),
              int'($urandom));
  endfunction

  task automatic drive(input bsg_tag_tx_req_s r);
    v = 1'b1; mr = r.master_reset; nid = r.node_id; dnr = r.data_not_reset; len = r.len; pay = r.payload;
  endtask

  task automatic scramble();
    v = 1'b0; mr = 1'($urandom); nid = 5'($urandom); dnr = 1'($urandom); len = 4'($urandom); pay = 15'($urandom);
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    chk_bit({tag, "_accept_timeout"}, n < 50, 1'b1);
    @(negedge clk);
  endtask

  task automatic expect_stream(input bsg_tag_tx_req_s r, input string tag);
    bitq_t q = build(r);
    foreach (q[i]) begin
      chk_bit({tag, "_bit"}, tdata, q[i]);
      chk_bit({tag, "_en"}, ten, 1'b1);
      @(negedge clk);
    end
    for (int i = 0; i < gap_lp; i++) begin
      chk_bit({tag, "_gap_bit"}, tdata, 1'b0);
      chk_bit({tag, "_gap_en"}, ten, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic expect_idle(input string tag);
    chk_bit({tag, "_ready"}, ready, 1'b1);
    chk_bit({tag, "_idle_en"}, ten, 1'b0);
    chk_bit({tag, "_idle_bit"}, tdata, 1'b0);
  endtask

  task automatic note_done(input bsg_tag_tx_req_s r);
    if (!r.master_reset)
      exp_client[r.node_id] = r.data_not_reset ? (r.payload & 15'((1 << r.len) - 1)) : 15'h0;
  endtask

  task automatic send(input bsg_tag_tx_req_s r, input string tag);
    if (r.master_reset) dec_en = 1'b0;
    drive(r);
    wait_accept(tag);
    scramble();
    expect_stream(r, tag);
    expect_idle(tag);
    dec_en = 1'b1;
    note_done(r);
  endtask

  // Client model: rebuilds packets from the wire and applies them per node
  int dph = 0, dcnt = 0;
  logic [31:0] dsh = '0;
  logic [4:0]  did = '0;
  logic        ddnr = 1'b0;
  logic [3:0]  dlen = '0;
  always @(negedge clk) begin
    bit done;
    done = 1'b0;
    if (!rst_n || !dec_en) dph = 0;
    else case (dph)
      0: if (tdata === 1'b1) begin dph = 1; dcnt = 0; dsh = '0; end
      1: begin
        dsh[dcnt] = tdata; dcnt++;
        if (dcnt == lg_els) begin did = dsh[4:0]; dph = 2; end
      end
      2: begin ddnr = tdata; dph = 3; dcnt = 0; dsh = '0; end
      3: begin
        dsh[dcnt] = tdata; dcnt++;
        if (dcnt == lg_w) begin
          dlen = dsh[3:0]; dcnt = 0; dsh = '0;
          if (dlen == 4'd0) done = 1'b1; else dph = 4;
        end
      end
      default: begin
        dsh[dcnt] = tdata; dcnt++;
        if (dcnt == int'(dlen)) done = 1'b1;
      end
    endcase
    if (done) begin
      client_data[did] = ddnr ? dsh[14:0] : 15'h0;
      dph = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bsg_tag_tx_req_s a, b, r;
    bitq_t q;

    repeat (3) @(negedge clk);
    chk_bit("reset_ready", ready, 1'b1);
    chk_bit("reset_data", tdata, 1'b0);
    chk_bit("reset_en", ten, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("post_reset");

    send(mk(1'b0, 5, 1'b1, 3, 5), "pkt_id5");
    send(mk(1'b1, 0, 1'b0, 0, 0), "master_reset");
    send(mk(1'b0, 0, 1'b0, 0, 0), "len0");
    send(mk(1'b0, 31, 1'b1, 15, 15'h5a3c), "len_max");

    a = mk(1'b0, 12, 1'b1, 7, 15'h0055);
    b = mk(1'b0, 20, 1'b1, 9, 15'h01c3);
    drive(a);
    wait_accept("b2b_a");
    drive(b);
    expect_stream(a, "b2b_a");
    note_done(a);
    chk_bit("b2b_reaccept_ready", ready, 1'b1);
    @(negedge clk);
    scramble();
    expect_stream(b, "b2b_b");
    note_done(b);
    expect_idle("b2b_end");
    repeat (3) @(negedge clk);
    chk_bit("b2b_no_dup", ten, 1'b0);

    r = mk(1'b0, 9, 1'b1, 10, 15'h3ff);
    q = build(r);
    drive(r);
    wait_accept("abort");
    scramble();
    for (int i = 0; i < 14; i++) begin
      chk_bit("abort_pre_bit", tdata, q[i]);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk_bit("abort_data", tdata, 1'b0);
    chk_bit("abort_en", ten, 1'b0);
    chk_bit("abort_ready", ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("abort_release");
    send(mk(1'b0, 9, 1'b1, 6, 15'h0029), "after_abort");

    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(7, 0) == 0) r = mk(1'b1, 0, 1'b0, 0, 0);
      else r = rand_req();
      send(r, "rand");
    end

    for (int n = 0; n < els_lp; n++) chk_word("client_data", client_data[n], exp_client[n]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
